// File: rtl/compare_eq_arbiter.sv
// Round-robin front end sharing one registered N-bit equality comparator among R requesters.
// Each requester has one compare in flight at most; its 1-bit result is held until consumed.
module compare_eq_arbiter #(
    parameter int N  = 10,
    parameter int R  = 4,
    parameter int CW = 32
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic [R-1:0]    req_valid,
    output logic [R-1:0]    req_ready,
    input  logic [R*N-1:0]  req_in0,
    input  logic [R*N-1:0]  req_in1,
    output logic [R-1:0]    rsp_valid,
    output logic [R-1:0]    rsp_eq,
    input  logic [R-1:0]    rsp_ready,
    output logic            busy,
    output logic [CW-1:0]   cmp_count
);

    localparam int TW = $clog2(R);

    logic [R-1:0]  pending;
    logic [R-1:0]  pending_nxt;
    logic [R-1:0]  rsp_valid_nxt;
    logic [R-1:0]  eligible;
    logic [TW-1:0] rr_ptr;
    logic [TW-1:0] next_ptr;
    logic [TW-1:0] grant;
    logic          grant_hit;
    logic          accept;
    logic [N-1:0]  sel_in0;
    logic [N-1:0]  sel_in1;

    logic          a_valid;
    logic [TW-1:0] a_tag;
    logic [N-1:0]  a_in0;
    logic [N-1:0]  a_in1;
    logic          a_eq;

    assign eligible = req_valid & ~pending;

    always_comb begin
        logic [TW:0] slot;
        // NOTE: every variable gets a default before the loop; a path that skips
        // an assignment in always_comb would otherwise infer a latch.
        grant     = rr_ptr;
        grant_hit = 1'b0;
        slot      = '0;
        for (int k = 0; k < R; k++) begin
            slot = {1'b0, rr_ptr} + (TW+1)'(k);
            if (slot >= (TW+1)'(R)) slot = slot - (TW+1)'(R);
            if (!grant_hit && eligible[slot[TW-1:0]]) begin
                grant_hit = 1'b1;
                grant     = slot[TW-1:0];
            end
        end
    end

    // Ready is forced low while reset is held so no requester sees a phantom accept.
    assign req_ready = (grant_hit && rstn) ? (R'(1) << grant) : '0;
    assign accept    = |req_ready;
    assign next_ptr  = (grant == TW'(R-1)) ? '0 : grant + 1'b1;

    always_comb begin
        sel_in0 = '0;
        sel_in1 = '0;
        for (int i = 0; i < R; i++) begin
            if (grant == TW'(i)) begin
                sel_in0 = req_in0[i*N +: N];
                sel_in1 = req_in1[i*N +: N];
            end
        end
    end

    // A requester with a result in flight cannot be granted, so the stage-B write
    // and a consumption never land on the same bit.
    always_comb begin
        pending_nxt   = pending & ~(rsp_valid & rsp_ready);
        rsp_valid_nxt = rsp_valid & ~rsp_ready;
        if (accept)  pending_nxt[grant]   = 1'b1;
        if (a_valid) rsp_valid_nxt[a_tag] = 1'b1;
    end

    assign a_eq = (a_in0 == a_in1);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rr_ptr    <= '0;
            a_valid   <= 1'b0;
            a_tag     <= '0;
            pending   <= '0;
            rsp_valid <= '0;
            rsp_eq    <= '0;
            cmp_count <= '0;
        end else begin
            a_valid   <= accept;
            pending   <= pending_nxt;
            rsp_valid <= rsp_valid_nxt;
            if (accept) begin
                a_tag     <= grant;
                rr_ptr    <= next_ptr;
                cmp_count <= cmp_count + CW'(1);
            end
            if (a_valid) rsp_eq[a_tag] <= a_eq;
        end
    end

    // NOTE: operand registers are deliberately not reset; a_valid qualifies them.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_in0 <= sel_in0;
            a_in1 <= sel_in1;
        end
    end

    assign busy = |pending;

endmodule

// File: tb/tb_compare_eq_arbiter.sv
// Self-checking bench for compare_eq_arbiter: directed scenarios plus random traffic,
// all checked every cycle against a transaction-level reference model.
module tb_compare_eq_arbiter;

    localparam int N  = 10;
    localparam int R  = 4;
    localparam int CW = 4;

    logic            clk;
    logic            rstn;
    logic [R-1:0]    req_valid;
    logic [R-1:0]    req_ready;
    logic [R*N-1:0]  req_in0;
    logic [R*N-1:0]  req_in1;
    logic [R-1:0]    rsp_valid;
    logic [R-1:0]    rsp_eq;
    logic [R-1:0]    rsp_ready;
    logic            busy;
    logic [CW-1:0]   cmp_count;

    compare_eq_arbiter #(.N(N), .R(R), .CW(CW)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_in0   (req_in0),
        .req_in1   (req_in1),
        .rsp_valid (rsp_valid),
        .rsp_eq    (rsp_eq),
        .rsp_ready (rsp_ready),
        .busy      (busy),
        .cmp_count (cmp_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: outstanding results as timed events, held results per requester.
    typedef struct {
        int who;
        bit eq;
        int land;
    } flight_t;

    flight_t fl[$];
    bit      m_pend[R];
    bit      m_rv[R];
    bit      m_eq[R];
    int      m_ptr;
    int      m_cnt;
    int      cyc = 0;
    int      last_grant;

    function automatic int pick();
        for (int k = 0; k < R; k++) begin
            int i = (m_ptr + k) % R;
            if (req_valid[i] && !m_pend[i]) return i;
        end
        return -1;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < R; i++) begin
            m_pend[i] = 1'b0;
            m_rv[i]   = 1'b0;
            m_eq[i]   = 1'b0;
        end
        fl.delete();
        m_ptr = 0;
        m_cnt = 0;
    endfunction

    // One clock cycle: compare all outputs, then advance the model across the edge.
    task automatic step();
        int            g;
        bit            geq;
        logic [R-1:0]  exp_ready;
        logic [R-1:0]  exp_rv;
        logic [R-1:0]  exp_eq;
        logic [CW-1:0] exp_cnt;
        logic          exp_busy;
        flight_t       w;
        #1;
        g = pick();
        exp_ready = '0;
        if (g >= 0) exp_ready[g] = 1'b1;
        exp_busy = 1'b0;
        for (int i = 0; i < R; i++) begin
            exp_rv[i] = m_rv[i];
            exp_eq[i] = m_eq[i];
            exp_busy  = exp_busy | m_pend[i];
        end
        exp_cnt = CW'(m_cnt);
        check("req_ready", 64'(req_ready), 64'(exp_ready));
        check("rsp_valid", 64'(rsp_valid), 64'(exp_rv));
        check("rsp_eq",    64'(rsp_eq),    64'(exp_eq));
        check("busy",      64'(busy),      64'(exp_busy));
        check("cmp_count", 64'(cmp_count), 64'(exp_cnt));
        geq = 1'b0;
        if (g >= 0) geq = (req_in0[g*N +: N] == req_in1[g*N +: N]);
        last_grant = g;
        @(posedge clk);
        for (int i = 0; i < R; i++) begin
            if (m_rv[i] && rsp_ready[i]) begin
                m_rv[i]   = 1'b0;
                m_pend[i] = 1'b0;
            end
        end
        while (fl.size() > 0 && fl[0].land == cyc) begin
            w = fl.pop_front();
            m_rv[w.who] = 1'b1;
            m_eq[w.who] = w.eq;
        end
        if (g >= 0) begin
            m_pend[g] = 1'b1;
            fl.push_back('{who: g, eq: geq, land: cyc + 1});
            m_ptr = (g + 1) % R;
            m_cnt++;
        end
        cyc++;
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        model_reset();
        #1;
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_eq",    64'(rsp_eq),    64'd0);
        check("rst_cmp_count", 64'(cmp_count), 64'd0);
        check("rst_busy",      64'(busy),      64'd0);
        check("rst_req_ready", 64'(req_ready), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    task automatic set_op(input int i, input logic [N-1:0] a, input logic [N-1:0] b);
        req_in0[i*N +: N] = a;
        req_in1[i*N +: N] = b;
    endtask

    task automatic rand_ops(input int i);
        logic [N-1:0] a;
        logic [N-1:0] b;
        a = N'($urandom);
        case ($urandom_range(0, 2))
            0:       b = a;
            1:       b = a ^ (N'(1) << $urandom_range(0, N - 1));
            default: b = N'($urandom);
        endcase
        set_op(i, a, b);
    endtask

    initial begin
        int acc;
        int acc2;
        int others;
        rstn      = 1'b0;
        req_valid = '0;
        req_ready_unused_guard();
        req_in0   = '0;
        req_in1   = '0;
        rsp_ready = '0;

        // 1: single request with equal operands, held result, then consumption.
        do_reset();
        req_valid = 4'b0001;
        set_op(0, 10'h2A, 10'h2A);
        step();
        req_valid = '0;
        step();
        check("t1_rsp_valid0", 64'(rsp_valid[0]), 64'd1);
        check("t1_rsp_eq0",    64'(rsp_eq[0]),    64'd1);
        repeat (5) step();
        rsp_ready = 4'b0001;
        step();
        rsp_ready = '0;
        #1;
        check("t1_consumed", 64'(rsp_valid[0]), 64'd0);
        check("t1_busy",     64'(busy),         64'd0);
        step();

        // 2: inequality in the LSB and in the MSB.
        do_reset();
        req_valid = 4'b0010;
        set_op(1, 10'h000, 10'h001);
        step();
        req_valid = '0;
        step();
        check("t2_lsb_eq", 64'(rsp_eq[1]), 64'd0);
        rsp_ready = 4'b0010;
        step();
        rsp_ready = '0;
        req_valid = 4'b0010;
        set_op(1, 10'h200, 10'h000);
        step();
        req_valid = '0;
        step();
        check("t2_msb_valid", 64'(rsp_valid[1]), 64'd1);
        check("t2_msb_eq",    64'(rsp_eq[1]),    64'd0);
        check("t2_count",     64'(cmp_count),    64'd2);
        rsp_ready = 4'b0010;
        step();
        rsp_ready = '0;

        // 3: all requesters valid, responses always consumed: strict rotation.
        do_reset();
        for (int i = 0; i < R; i++) set_op(i, N'(i * 3), N'(i * 3));
        req_valid = '1;
        rsp_ready = '1;
        for (int k = 0; k < 8; k++) begin
            step();
            check("t3_grant_order", 64'(last_grant), 64'(k % R));
        end
        check("t3_count", 64'(cmp_count), 64'd8);

        // 4: req2 never consumes its result, so it is accepted exactly once.
        do_reset();
        acc2   = 0;
        others = 0;
        for (int k = 0; k < 60; k++) begin
            req_valid = 4'($urandom) | 4'b0100;
            rsp_ready = 4'($urandom) & 4'b1011;
            for (int i = 0; i < R; i++) rand_ops(i);
            step();
            if (last_grant == 2) acc2++;
            else if (last_grant >= 0) others++;
        end
        check("t4_req2_accepts", 64'(acc2), 64'd1);
        check("t4_others_served", 64'(others > 0), 64'd1);

        // 5: asynchronous reset between accept and result discards the compare.
        rsp_ready = '0;
        do_reset();
        req_valid = 4'b0100;
        set_op(2, 10'h155, 10'h155);
        step();
        req_valid = 4'b1010;
        #2;
        rstn = 1'b0;
        model_reset();
        #1;
        check("t5_rsp_valid", 64'(rsp_valid), 64'd0);
        check("t5_count",     64'(cmp_count), 64'd0);
        check("t5_req_ready", 64'(req_ready), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        step();
        check("t5_first_grant", 64'(last_grant), 64'd1);
        req_valid = '0;
        repeat (3) step();

        // 6: counter wraps modulo 2^CW after 17 accepts.
        do_reset();
        req_valid = '1;
        rsp_ready = '1;
        acc = 0;
        for (int k = 0; k < 100 && acc < 17; k++) begin
            for (int i = 0; i < R; i++) rand_ops(i);
            step();
            if (last_grant >= 0) acc++;
        end
        check("t6_accepts", 64'(acc), 64'd17);
        check("t6_count_wrap", 64'(cmp_count), 64'd1);

        // Random traffic with random back-pressure on responses.
        for (int k = 0; k < 400; k++) begin
            req_valid = 4'($urandom);
            rsp_ready = 4'($urandom) | 4'($urandom);
            for (int i = 0; i < R; i++) rand_ops(i);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Clears bench-side grant tracking before the first scenario.
    task automatic req_ready_unused_guard();
        last_grant = -1;
    endtask

endmodule

// File: doc/compare_eq_arbiter.md
Name: compare_eq_arbiter

Overview:
- Shares one registered N-bit equality comparator among R requesters.
- Each requester sends an operand pair over a valid/ready handshake and gets its own 1-bit equal/not-equal result back on a valid/ready response channel.
- A round-robin arbiter issues at most one compare per cycle; per-requester pending tracking prevents result overwrite.
- Sits between TyTra stream lanes and a single shared comparison core, for area-constrained kernels.

Parameters:
- N, 10, operand width in bits (1..64).
- R, 4, number of requesters (2..8).
- CW, 32, width of the performance counter cmp_count.

Ports:
- clk  input  1  single clock; all state on the rising edge.
- rstn  input  1  asynchronous, active-low reset.
- req_valid  input  R  bit i: requester i presents an operand pair.
- req_ready  output  R  bit i: requester i's pair is accepted this cycle (one-hot or zero).
- req_in0  input  R*N  operand A; requester i occupies bits [i*N +: N].
- req_in1  input  R*N  operand B; same packing as req_in0.
- rsp_valid  output  R  bit i: result for requester i is held.
- rsp_eq  output  R  bit i: 1 if in0==in1 for requester i's last accepted pair.
- rsp_ready  input  R  bit i: requester i consumes its result.
- busy  output  1  high if any pending bit is set.
- cmp_count  output  CW  number of accepted compares; wraps modulo 2^CW.

Behaviour:
- Reset (rstn low, asynchronous): all of the following are cleared.
  - rsp_valid=0, rsp_eq=0, pending=0, stage-A valid=0, rr_ptr=0, cmp_count=0, busy=0.
  - req_ready is 0 while in reset.
  - In-flight compares are discarded, with no response.
- Eligibility: requester i is eligible iff req_valid[i] && !pending[i].
- Arbitration (combinational):
  - Search eligible requesters starting at rr_ptr, ascending, wrapping modulo R.
  - The first hit is granted and req_ready[grant]=1; all other req_ready bits are 0.
  - req_ready depends only on req_valid and internal state, never on rsp_ready.
- On a handshake with requester g in cycle t:
  - Stage-A registers load in0/in1 for requester g, with tag=g and valid=1.
  - pending[g] is set.
  - rr_ptr becomes (g+1) mod R.
  - cmp_count increments.
- With no handshake, rr_ptr holds and stage-A valid becomes 0.
- Stage B (cycle t+1): the comparator evaluates the stage-A operands. At the edge, rsp_eq[tag] is loaded and rsp_valid[tag] is set.
- Latency: the result is visible from cycle t+2. Throughput is one compare per cycle in aggregate, and one outstanding compare per requester.
- Response handshake: rsp_valid[i] && rsp_ready[i] clears rsp_valid[i] and pending[i] at that edge.
  - Requester i may be granted again in the following cycle, not the same cycle.
- rsp_valid[i] and rsp_eq[i] hold stable until consumed; rsp_ready while rsp_valid=0 is ignored.
- Result writes and consumption target different requesters by construction, so they cannot conflict.
- busy = OR(pending).
- Comparison is unsigned bitwise equality on all N bits. There are no X-propagation assumptions; a single-bit difference yields 0.
- Requesters are expected to hold req_in0/req_in1 stable while req_valid is high and unaccepted. The block samples only on the handshake cycle.
- Simultaneous events:
  - Grant and a response to different requesters in the same cycle are both honoured.
  - If all requesters are eligible, grants rotate 0,1,2,...,R-1, given that responses are consumed.
- Starvation-free: an eligible requester is granted within R cycles.

Test Plan:
1. Reset then single request: req0 in0=in1=10'h2A accepted at t. Expect rsp_valid[0]=1 and rsp_eq[0]=1 at t+2; hold with rsp_ready=0 for 5 cycles; result stays stable; pulse rsp_ready, then rsp_valid[0]=0 and busy=0.
2. Inequality, LSB and MSB: req1 pairs (0x000, 0x001) and (0x200, 0x000). Expect rsp_eq[1]=0 for each; cmp_count=2.
3. All four requesters valid continuously with rsp_ready=1. Expect grants in order 0,1,2,3,0,... with no back-to-back grant to the same requester; cmp_count=8 after 8 accepts.
4. Pending block: req2 stays valid and never asserts rsp_ready. Expect exactly one accept for req2, req_ready[2]=0 thereafter, and other requesters still served.
5. Asynchronous reset mid-flight: assert rstn=0 between accept and result (t+1). Expect all rsp_valid=0, cmp_count=0 and rr_ptr=0 immediately; after release the first grant goes to the lowest valid index.
6. Counter wrap with CW=4: 17 accepts. Expect cmp_count=1.
